// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the decoder's FIFO read arbiters.
//   arb_state_t  : arbiter FSM states (IDLE / READ / GAP)
//   BURST_CNT_W  : width of the per-grant read counter
//   GAP_CNT_W    : width of the inter-read pacing counter
//   clog2()      : index width for a port count, never less than 1
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int unsigned BURST_CNT_W = 8;
    localparam int unsigned GAP_CNT_W   = 3;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rr_pick: combinational first-set-bit selector searching upward from ptr
// with wrap-around. Shared by the decoder's round-robin arbiters.
//   req   : request vector, one bit per port
//   ptr   : search start index (must be < N)
//   grant : index of the first requesting port at or after ptr
//   any   : at least one request is set
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic [clog2(N)-1:0]   grant,
    output logic                  any
);

    localparam int unsigned IW = clog2(N);

    logic [IW-1:0] idx;

    // Walk N positions from ptr; explicit wrap so N need not be a power of 2.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = ptr;
        for (int i = 0; i < int'(N); i++) begin
            if (!any && req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
            idx = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin read scheduler draining NUM_PORTS
// single-clock FIFOs into one output stream, BURST_LEN reads per grant,
// with READ_GAP idle cycles after every read so the FIFOs' registered
// empty flags settle before the next read decision.
//
// Ports:
//   clk         : clock (FIFO read side and arbiter)
//   rst         : synchronous active-low reset
//   fifo_empty  : per-FIFO empty flag
//   fifo_valid  : per-FIFO read acknowledge (cycle after rd_en)
//   fifo_dout   : per-FIFO data, port i at [i*data_width +: data_width]
//   fifo_rd_en  : read enable, one-hot or zero; decoded from registered
//                 state in the same cycle as the read so the FIFO sees it
//                 on the edge that performs the read
//   out_stall   : downstream back-pressure, blocks new reads only
//   dout        : registered output data
//   dout_valid  : one-cycle strobe qualifying dout (rd_en at t -> t+2)
//   dout_src    : index of the FIFO that supplied dout
//   busy        : arbiter is not in IDLE
//
// Build option FIFO_RD_ARB_PRIO0_EN: port 0 wins every arbitration it
// requests and its bursts leave rr_ptr untouched; other ports stay
// round-robin. Port 0 can starve the others by design.
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned data_width = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned READ_GAP   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             fifo_empty,
    input  logic [NUM_PORTS-1:0]             fifo_valid,
    input  logic [NUM_PORTS*data_width-1:0]  fifo_dout,
    output logic [NUM_PORTS-1:0]             fifo_rd_en,
    input  logic                             out_stall,
    output logic [data_width-1:0]            dout,
    output logic                             dout_valid,
    output logic [clog2(NUM_PORTS)-1:0]      dout_src,
    output logic                             busy
);

    localparam int unsigned IW    = clog2(NUM_PORTS);
    localparam int unsigned BCN_W = BURST_CNT_W + 1;

    arb_state_t             state;
    logic [IW-1:0]          grant;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          sel_d;
    logic [IW-1:0]          pick_grant;
    logic [IW-1:0]          arb_grant;
    logic [IW-1:0]          next_ptr;
    logic                   pick_any;
    logic                   ptr_hold;
    logic                   rd_pend;
    logic                   rd_fire;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [GAP_CNT_W-1:0]   gap_cnt;
    logic [data_width-1:0]  dout_arr [NUM_PORTS];

    rr_pick #(
        .N     (NUM_PORTS)
    ) u_pick (
        .req   (~fifo_empty),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .any   (pick_any)
    );

`ifdef FIFO_RD_ARB_PRIO0_EN
    // Port 0 overrides the round-robin choice and does not advance the pointer.
    assign arb_grant = fifo_empty[0] ? pick_grant : '0;
    assign ptr_hold  = (grant == '0);
`else
    assign arb_grant = pick_grant;
    assign ptr_hold  = 1'b0;
`endif

    assign next_ptr = (grant == IW'(NUM_PORTS - 1)) ? '0 : grant + IW'(1);

    // A read fires only to a granted, non-empty FIFO while downstream accepts.
    assign rd_fire    = (state == ST_READ) && !fifo_empty[grant] && !out_stall;
    assign fifo_rd_en = rd_fire ? (NUM_PORTS'(1) << grant) : '0;

    // Unpack the flat data bus for indexing by the registered source select.
    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            dout_arr[i] = fifo_dout[i*int'(data_width) +: data_width];
        end
    end

    // Arbitration / burst / pacing FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any && !out_stall) begin
                        grant     <= arb_grant;
                        burst_cnt <= '0;
                        state     <= ST_READ;
                        busy      <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (!fifo_empty[grant]) begin
                        if (!out_stall) begin
                            burst_cnt <= burst_cnt + BURST_CNT_W'(1);
                            if (!(READ_GAP == 0 &&
                                  (BCN_W'(burst_cnt) + BCN_W'(1)) < BCN_W'(BURST_LEN))) begin
                                state   <= ST_GAP;
                                gap_cnt <= GAP_CNT_W'(READ_GAP);
                            end
                        end
                    end else begin
                        // Granted FIFO ran dry: close the burst early.
                        rr_ptr <= ptr_hold ? rr_ptr : next_ptr;
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt > GAP_CNT_W'(1)) begin
                        gap_cnt <= gap_cnt - GAP_CNT_W'(1);
                    end else begin
                        gap_cnt <= '0;
                        if (burst_cnt == BURST_CNT_W'(BURST_LEN)) begin
                            rr_ptr <= ptr_hold ? rr_ptr : next_ptr;
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Return path: capture the FIFO response one cycle after its rd_en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_src   <= '0;
            sel_d      <= '0;
            rd_pend    <= 1'b0;
        end else begin
            rd_pend    <= rd_fire;
            dout_valid <= 1'b0;
            if (rd_fire) begin
                sel_d <= grant;
            end
            // A missing acknowledge (underflow) leaves dout unchanged.
            if (rd_pend && fifo_valid[sel_d]) begin
                dout       <= dout_arr[sel_d];
                dout_src   <= sel_d;
                dout_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter (4 ports, BURST_LEN 4, READ_GAP 2).
// FIFO models are queues with registered empty/valid; directed tests push
// hand-ordered expected words, a negedge monitor pops and compares.
// Builds with or without FIFO_RD_ARB_PRIO0_EN.
`timescale 1ns/1ps
module tb_fifo_rd_arbiter;
    import fifo_arb_pkg::*;

    localparam int NP    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NP-1:0]   fifo_empty;
    logic [NP-1:0]   fifo_valid;
    logic [NP*DW-1:0] fifo_dout;
    logic [NP-1:0]   fifo_rd_en;
    logic            out_stall = 1'b0;
    logic [DW-1:0]   dout;
    logic            dout_valid;
    logic [1:0]      dout_src;
    logic            busy;

    always #5 clk = ~clk;

    fifo_rd_arbiter #(
        .NUM_PORTS  (NP),
        .data_width (DW),
        .BURST_LEN  (4),
        .READ_GAP   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_stall  (out_stall),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_src   (dout_src),
        .busy       (busy)
    );

    // FIFO models
    logic [DW-1:0] mem [NP][DEPTH];
    int            head [NP] = '{default: 0};
    int            tail [NP] = '{default: 0};
    logic [NP-1:0] empty_r = '1;
    logic [NP-1:0] valid_r = '0;
    logic [DW-1:0] dout_r [NP] = '{default: '0};
    int            cyc = 0;

    assign fifo_empty = empty_r;
    assign fifo_valid = valid_r;

    always_comb begin
        fifo_dout = '0;
        for (int p = 0; p < NP; p++) fifo_dout[p*DW +: DW] = dout_r[p];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int p = 0; p < NP; p++) begin
            if (fifo_rd_en[p] && (tail[p] != head[p])) begin
                dout_r[p]  <= mem[p][head[p] % DEPTH];
                head[p]    <= head[p] + 1;
                valid_r[p] <= 1'b1;
                empty_r[p] <= (tail[p] == head[p] + 1);
            end else begin
                valid_r[p] <= 1'b0;
                empty_r[p] <= (tail[p] == head[p]);
            end
        end
    end

    // Scoreboard state and logs
    logic [9:0] exp_q [$];
    int         rd_cyc [$];
    int         rd_port [$];
    int         dv_cyc [$];
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic int port_of(input logic [NP-1:0] v);
        for (int p = 0; p < NP; p++) if (v[p]) return p;
        return -1;
    endfunction

    // Monitor: log reads, pop and compare every output word.
    always @(negedge clk) begin : mon
        logic [9:0] e;
        if (fifo_rd_en != '0) begin
            check("rd_en_onehot", 32'($onehot(fifo_rd_en)), 32'd1);
            check("rd_en_to_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
            rd_cyc.push_back(cyc);
            rd_port.push_back(port_of(fifo_rd_en));
        end
        if (dout_valid) begin
            dv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_dout: got src %0d data 0x%0h, expected none",
                         dout_src, dout);
            end else begin
                e = exp_q.pop_front();
                check("dout_src_data", 32'({dout_src, dout}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int p, input logic [7:0] d);
        mem[p][tail[p] % DEPTH] = d;
        tail[p] = tail[p] + 1;
    endtask

    task automatic expect_word(input int src, input logic [7:0] d);
        exp_q.push_back({2'(src), d});
    endtask

    // Return at negedge+2 of the cycle in which the n-th read (from base) is seen.
    task automatic wait_reads(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (rd_cyc.size() < n && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        check(name, 32'(rd_cyc.size() >= n), 32'd1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        check(name, 32'(exp_q.size() == 0 && !busy), 32'd1);
        repeat (3) tick();
    endtask

    initial begin : stim
        int rb;
        int db;

        repeat (3) tick();
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_dout_valid", 32'(dout_valid), 32'd0);
        check("reset_dout_src", 32'(dout_src), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        check("reset_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        rst = 1'b1;
        tick();

`ifdef FIFO_RD_ARB_PRIO0_EN
        // Port 0 strict priority: ports 0 and 3 both loaded, only port 0 served.
        rb = rd_cyc.size();
        for (int k = 0; k < 40; k++) begin
            push_word(0, 8'(k));
            push_word(3, 8'(8'h30 + k));
        end
        for (int k = 0; k < 12; k++) expect_word(0, 8'(k));
        wait_reads(rb + 12, 200, "prio_wait_reads");
        tick();
        out_stall = 1'b1;
        wait_drain(100, "prio_drain");
        check("prio_read_count", 32'(rd_cyc.size() - rb), 32'd12);
        for (int i = 0; i < 12; i++)
            check($sformatf("prio_port%0d", i), 32'(rd_port[rb+i]), 32'd0);
        check("prio_rr_ptr", 32'(dut.rr_ptr), 32'd0);
`else
        // Fairness: ports 0 and 2 with 8 words each alternate in bursts of 4.
        rb = rd_cyc.size();
        db = dv_cyc.size();
        for (int k = 0; k < 8; k++) begin
            push_word(0, 8'(k));
            push_word(2, 8'(8'h20 + k));
        end
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 4; k++)
                expect_word((b % 2 == 0) ? 0 : 2,
                            8'(((b % 2 == 0) ? 8'h00 : 8'h20) + (b / 2) * 4 + k));
        wait_drain(300, "fair_drain");
        check("fair_read_count", 32'(rd_cyc.size() - rb), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("fair_port%0d", i), 32'(rd_port[rb+i]),
                  ((i / 4) % 2 == 0) ? 32'd0 : 32'd2);
        for (int i = 1; i < 16; i++)
            check($sformatf("fair_spacing%0d", i), 32'(rd_cyc[rb+i] - rd_cyc[rb+i-1]),
                  (i % 4 == 0) ? 32'd4 : 32'd3);
        check("fair_latency", 32'(dv_cyc[db] - rd_cyc[rb]), 32'd2);
        check("fair_rr_ptr", 32'(dut.rr_ptr), 32'd3);

        // Short FIFO: port 1 with 2 words; burst ends when empty is seen.
        rb = rd_cyc.size();
        push_word(1, 8'h10);
        push_word(1, 8'h11);
        expect_word(1, 8'h10);
        expect_word(1, 8'h11);
        wait_drain(100, "short_drain");
        check("short_read_count", 32'(rd_cyc.size() - rb), 32'd2);
        check("short_spacing", 32'(rd_cyc[rb+1] - rd_cyc[rb]), 32'd3);
        check("short_busy", 32'(busy), 32'd0);
        check("short_rr_ptr", 32'(dut.rr_ptr), 32'd2);

        // Stall: 5 stalled cycles after the first read of a port-2 burst.
        rb = rd_cyc.size();
        db = dv_cyc.size();
        for (int k = 0; k < 4; k++) begin
            push_word(2, 8'(8'h28 + k));
            expect_word(2, 8'(8'h28 + k));
        end
        wait_reads(rb + 1, 50, "stall_wait_first");
        tick();
        out_stall = 1'b1;
        repeat (5) tick();
        out_stall = 1'b0;
        wait_drain(100, "stall_drain");
        check("stall_read_count", 32'(rd_cyc.size() - rb), 32'd4);
        check("stall_latency", 32'(dv_cyc[db] - rd_cyc[rb]), 32'd2);
        check("stall_resume", 32'(rd_cyc[rb+1] - rd_cyc[rb]), 32'd6);
        check("stall_spacing2", 32'(rd_cyc[rb+2] - rd_cyc[rb+1]), 32'd3);
        check("stall_spacing3", 32'(rd_cyc[rb+3] - rd_cyc[rb+2]), 32'd3);
        check("stall_rr_ptr", 32'(dut.rr_ptr), 32'd3);

        // Wrap: rr_ptr 3, only port 0 pending -> grant 0, pointer to 1.
        rb = rd_cyc.size();
        for (int k = 0; k < 4; k++) begin
            push_word(0, 8'(8'h08 + k));
            expect_word(0, 8'(8'h08 + k));
        end
        wait_drain(100, "wrap_drain");
        check("wrap_read_count", 32'(rd_cyc.size() - rb), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("wrap_port%0d", i), 32'(rd_port[rb+i]), 32'd0);
        check("wrap_rr_ptr", 32'(dut.rr_ptr), 32'd1);

        // Reset mid-burst: rst low during the 2nd read; its response is dropped.
        rb = rd_cyc.size();
        db = dv_cyc.size();
        for (int k = 0; k < 4; k++) push_word(1, 8'(8'h12 + k));
        expect_word(1, 8'h12);
        wait_reads(rb + 2, 50, "rst_wait_reads");
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout_src", 32'(dout_src), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        check("rst_fifo_ack_seen", 32'(fifo_valid[1]), 32'd1);
        @(negedge clk);
        #2;
        check("rst_discard", 32'(dout_valid), 32'd0);
        repeat (3) tick();
        check("rst_dout_count", 32'(dv_cyc.size() - db), 32'd1);
        check("rst_exp_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
